hyper_rx_ctrl: RTL
==================

Name: hyper_rx_ctrl

Overview:
Read-burst sequencer for the HyperBus DDR input capture path. It accepts a read command with a word count and drives the capture enable. It counts 16-bit words arriving from the capture stage on rx_valid_i and buffers them in a small FIFO toward a ready/valid consumer. It reports completion, first-word/inter-word timeout and overflow, because the RWDS-timed capture path cannot be back-pressured.

Parameters:
LEN_W, 16, width of burst length in 16-bit words
FIFO_DEPTH, 4, output buffer depth in words (power of two, >=2)
TIMEOUT, 64, max clk0 cycles waiting for first word and between consecutive words
TO_W, 8, timeout counter width (must hold TIMEOUT)

Ports:
clk0  in  1  system/controller clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  read command request
cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o
cmd_len_i  in  LEN_W  number of 16-bit words to receive
rx_en_o  out  1  enable to capture stage
rx_data_i  in  16  captured word from capture stage (already in clk0 domain)
rx_valid_i  in  1  one-cycle word strobe from capture stage
data_o  out  16  buffered word to consumer
valid_o  out  1  data_o valid
ready_i  in  1  consumer ready
busy_o  out  1  burst in progress (state != IDLE)
done_o  out  1  one-cycle pulse: last word of burst pushed into FIFO
err_timeout_o  out  1  sticky timeout flag, cleared on next command accept
err_overflow_o  out  1  sticky overflow flag, cleared on next command accept

Behaviour:
- Reset (async, rst_ni=0): state IDLE; cmd_ready_o=1, rx_en_o=0, valid_o=0, data_o=16'h0, busy_o=0, done_o=0, both err flags 0; FIFO empty; counters 0.
- States: IDLE, WAIT_FIRST, RECV, ABORT.
- IDLE: cmd_ready_o=1. On handshake: latch len, clear err flags, zero timeout counter.
  - len==0: pulse done_o next cycle, stay IDLE, rx_en_o never asserted.
  - len>0: go WAIT_FIRST; rx_en_o=1 from the next cycle.
- WAIT_FIRST/RECV: cmd_ready_o=0, rx_en_o=1. Timeout counter increments each cycle without rx_valid_i and resets to 0 on rx_valid_i.
  - rx_valid_i: push rx_data_i, decrement remaining count, WAIT_FIRST->RECV.
  - Push of final word (remaining==1): done_o=1 that cycle-registered (pulse the cycle after the push), rx_en_o=0 same cycle as done_o, return IDLE.
- Timeout: counter reaches TIMEOUT-1 with no strobe -> set err_timeout_o, go ABORT.
- Overflow: rx_valid_i while FIFO full and no simultaneous pop -> word dropped, set err_overflow_o, go ABORT.
  - Simultaneous push+pop on full FIFO is legal, not overflow.
- ABORT: rx_en_o=0, no done_o; ignore rx_valid_i; return IDLE after one cycle. FIFO contents already pushed remain and drain normally.
- FIFO: push on accepted rx_valid_i; pop on valid_o & ready_i. valid_o = !empty, data_o = head word (first-word fall-through).
  - Zero-latency from push to valid_o is NOT required: valid_o rises the cycle after push.
  - Pointer wrap modulo FIFO_DEPTH with extra wrap bit for full/empty.
- rx_valid_i outside WAIT_FIRST/RECV: ignored, no push.
- New command may be accepted while FIFO still holds data from the previous burst; order preserved.
- Async reset mid-burst: everything returns to reset values immediately; FIFO contents lost.
- Word ordering: data_o bits [15:8] are first (rising-edge) byte, [7:0] second, unchanged from rx_data_i.

Decomposition:
- Shared package hyper_rx_pkg: state enum rx_state_e {IDLE, WAIT_FIRST, RECV, ABORT}, word width constant HYPER_WORD_W=16.
- One sub-module: hyper_rx_fifo (parameterised sync FIFO, depth FIFO_DEPTH, push/pop/full/empty/data). FSM, counters and error flags stay in hyper_rx_ctrl.

Test Plan:
- len=4, rx_valid_i every 2 cycles with 16'hA001..A004, ready_i=1 -> data_o sequence A001..A004, done_o single pulse after 4th push, rx_en_o low afterward, no errors.
- len=0 command -> done_o pulse one cycle later, rx_en_o stays 0, cmd_ready_o stays 1.
- len=3, only one word then silence, TIMEOUT=64 -> err_timeout_o set 64 cycles after last strobe, state IDLE, no done_o, one word drained.
- len=8, ready_i=0, back-to-back strobes -> 4 words stored, 5th sets err_overflow_o, ABORT, raising ready_i yields first 4 words only.
- FIFO full, ready_i=1 and rx_valid_i same cycle -> no overflow, count unchanged, order kept.
- Assert rst_ni low mid-burst (after 2 of 4 words) -> all outputs at reset values immediately; new len=2 command completes normally.

Source files
------------

// File: rtl/hyper_rx_pkg.sv
// Shared types and constants for the HyperBus read-capture controller.
//   rx_state_e   : burst sequencer states
//   HYPER_WORD_W : width of one captured HyperBus word (two DDR bytes)
package hyper_rx_pkg;

  localparam int unsigned HYPER_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    RECV,
    ABORT
  } rx_state_e;

endpackage

// File: rtl/hyper_rx_fifo.sv
// Small synchronous FIFO buffering captured words toward the consumer.
// Head word is presented combinationally (first-word fall-through); a
// pushed word becomes visible the cycle after the push.
//   clk0, rst_ni : clock, asynchronous active-low reset
//   push         : write push_data (caller guarantees not full, or pop same cycle)
//   push_data    : word to store
//   pop          : discard head word (caller guarantees not empty)
//   data         : head word, zero while empty
//   full, empty  : occupancy flags
module hyper_rx_fifo
  import hyper_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk0,
  input  logic                    rst_ni,
  input  logic                    push,
  input  logic [HYPER_WORD_W-1:0] push_data,
  input  logic                    pop,
  output logic [HYPER_WORD_W-1:0] data,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [HYPER_WORD_W-1:0] mem [DEPTH];
  logic [AW:0]             wptr;
  logic [AW:0]             rptr;

  // Extra MSB on each pointer distinguishes full from empty when the
  // index bits coincide.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign data  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk0 or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk0) begin
    if (push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/hyper_rx_ctrl.sv
// HyperBus read-burst sequencer. Accepts a read command with a word count,
// enables the capture stage, counts incoming words into an output FIFO and
// reports completion, timeout and overflow (capture cannot be stalled).
//   cmd_valid_i/cmd_ready_o/cmd_len_i : read command handshake and length
//   rx_en_o                           : capture stage enable
//   rx_data_i/rx_valid_i              : captured word and one-cycle strobe
//   data_o/valid_o/ready_i            : buffered words to consumer
//   busy_o                            : burst in progress
//   done_o                            : pulse after final word pushed
//   err_timeout_o/err_overflow_o      : sticky errors, cleared on next command
module hyper_rx_ctrl
  import hyper_rx_pkg::*;
#(
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned TO_W       = 8
) (
  input  logic                    clk0,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [LEN_W-1:0]        cmd_len_i,
  output logic                    rx_en_o,
  input  logic [HYPER_WORD_W-1:0] rx_data_i,
  input  logic                    rx_valid_i,
  output logic [HYPER_WORD_W-1:0] data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_timeout_o,
  output logic                    err_overflow_o
);

  rx_state_e        state;
  logic [LEN_W-1:0] remaining;
  logic [TO_W-1:0]  to_cnt;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic active;
  logic overflow_hit;
  logic push;

  assign valid_o      = !fifo_empty;
  assign pop          = valid_o && ready_i;
  assign active       = (state == WAIT_FIRST) || (state == RECV);
  // A pop in the same cycle frees a slot, so full+push+pop is not overflow.
  assign overflow_hit = active && rx_valid_i && fifo_full && !pop;
  assign push         = active && rx_valid_i && !overflow_hit;

  hyper_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk0      (clk0),
    .rst_ni    (rst_ni),
    .push      (push),
    .push_data (rx_data_i),
    .pop       (pop),
    .data      (data_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk0 or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      remaining      <= '0;
      to_cnt         <= '0;
      cmd_ready_o    <= 1'b1;
      rx_en_o        <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_timeout_o  <= 1'b0;
      err_overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            err_timeout_o  <= 1'b0;
            err_overflow_o <= 1'b0;
            to_cnt         <= '0;
            if (cmd_len_i == '0) begin
              done_o <= 1'b1;
            end else begin
              remaining   <= cmd_len_i;
              state       <= WAIT_FIRST;
              rx_en_o     <= 1'b1;
              cmd_ready_o <= 1'b0;
              busy_o      <= 1'b1;
            end
          end
        end
        WAIT_FIRST, RECV: begin
          if (rx_valid_i) begin
            to_cnt <= '0;
            if (overflow_hit) begin
              err_overflow_o <= 1'b1;
              rx_en_o        <= 1'b0;
              state          <= ABORT;
            end else if (remaining == LEN_W'(1)) begin
              remaining   <= '0;
              done_o      <= 1'b1;
              rx_en_o     <= 1'b0;
              cmd_ready_o <= 1'b1;
              busy_o      <= 1'b0;
              state       <= IDLE;
            end else begin
              remaining <= remaining - 1'b1;
              state     <= RECV;
            end
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            err_timeout_o <= 1'b1;
            rx_en_o       <= 1'b0;
            state         <= ABORT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ABORT: begin
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
